// File: rtl/iter_shifter_pkg.sv
// Shared shifter constants: operation codes as seen by the decoder and the
// sequencer state encodings of iter_shifter.
package iter_shifter_pkg;

    typedef enum logic [1:0] {
        SHOP_SLL  = 2'b00,
        SHOP_SRL  = 2'b01,
        SHOP_ROTR = 2'b10,
        SHOP_SRA  = 2'b11
    } shop_t;

    typedef enum logic [1:0] {
        SHST_IDLE  = 2'b00,
        SHST_SHIFT = 2'b01,
        SHST_DONE  = 2'b10
    } shst_t;

    // Width of the per-cycle shift amount, wide enough to hold 0..step.
    function automatic int step_k_w(input int step);
        return $clog2(step) + 1;
    endfunction

endpackage

// File: rtl/iter_shifter_shift_step.sv
// One combinational shift/rotate step of 0..STEP bit positions on the
// accumulator of iter_shifter.
module shift_step
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int KW    = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [1:0]       op,
    input  logic [KW-1:0]    k,
    output logic [WIDTH-1:0] res
);

    logic signed [WIDTH-1:0] acc_s;
    logic        [31:0]      amt;

    assign acc_s = $signed(acc);
    assign amt   = 32'(k);

    // A rotate by zero shifts the wrap-around term by WIDTH, which yields zero.
    always_comb begin
        res = acc;
        case (op)
            SHOP_SLL:  res = acc << amt;
            SHOP_SRL:  res = acc >> amt;
            SHOP_SRA:  res = acc_s >>> amt;
            SHOP_ROTR: res = (acc >> amt) | (acc << (32'(WIDTH) - amt));
            default:   res = acc;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: moves up to STEP bit positions per clock and
// signals completion with a one-cycle done pulse.
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int STEP    = 4,
    localparam int SHAMT_W = $clog2(WIDTH),
    localparam int KW      = $clog2(STEP) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    shst_t              state;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   acc;
    logic [SHAMT_W-1:0] rem;

    logic [KW-1:0]      k;
    logic [SHAMT_W-1:0] rem_next;
    logic [WIDTH-1:0]   acc_next;
    logic               accept;

    // k = min(rem, STEP); rem never reaches WIDTH so STEP == WIDTH is safe.
    always_comb begin
        k = KW'(rem);
        if (32'(rem) >= 32'(STEP)) begin
            k = KW'(STEP);
        end
        rem_next = rem - SHAMT_W'(k);
    end

    assign accept = start && (state == SHST_IDLE || state == SHST_DONE);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .acc   (acc),
        .op    (op_q),
        .k     (k),
        .res   (acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SHST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            op_q  <= 2'b00;
            acc   <= '0;
            rem   <= '0;
        end else begin
            case (state)
                SHST_IDLE, SHST_DONE: begin
                    if (accept) begin
                        op_q <= op;
                        acc  <= operand;
                        rem  <= shamt;
                        if (shamt == '0) begin
                            state <= SHST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= SHST_SHIFT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= SHST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                SHST_SHIFT: begin
                    acc <= acc_next;
                    rem <= rem_next;
                    if (rem_next == '0) begin
                        state <= SHST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= SHST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign result = acc;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter at WIDTH = 32, STEP = 4.
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] operand = '0;
    logic [4:0]  shamt = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    iter_shifter #(.WIDTH(32), .STEP(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .operand (operand),
        .shamt   (shamt),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request so it is accepted at the next rising edge; returns at
    // the falling edge one cycle after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s);
        start   = 1'b1;
        op      = o;
        operand = v;
        shamt   = s;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // Latency counts cycles after the accepting edge up to and including the done cycle.
    task automatic wait_done(input int max, output int lat, output int bcnt);
        lat  = 1;
        bcnt = 0;
        while (done !== 1'b1 && lat < max) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] v,
                          input logic [4:0] s, input int exp_lat, input logic [31:0] exp_res);
        int lat;
        int bcnt;
        issue(o, v, s);
        wait_done(20, lat, bcnt);
        chk({tag, "_done"},    32'(done), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_busycyc"}, 32'(bcnt), 32'(exp_lat - 1));
        chk({tag, "_busylow"}, 32'(busy), 32'd0);
        chk({tag, "_result"},  result, exp_res);
        @(negedge clk);
        chk({tag, "_pulse"},   32'(done), 32'd0);
        chk({tag, "_hold"},    result, exp_res);
    endtask

    initial begin
        int lat;
        int bcnt;
        int ndone;
        int done_at;

        repeat (2) @(negedge clk);
        chk("rst_busy",   32'(busy), 32'd0);
        chk("rst_done",   32'(done), 32'd0);
        chk("rst_result", result, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_op("sll3",    2'b00, 32'h0000_0001, 5'd3,  2, 32'h0000_0008);
        run_op("sra31",   2'b11, 32'h8000_0000, 5'd31, 9, 32'hFFFF_FFFF);
        run_op("srl31",   2'b01, 32'h8000_0000, 5'd31, 9, 32'h0000_0001);
        run_op("rotr4",   2'b10, 32'h0000_0001, 5'd4,  2, 32'h1000_0000);
        run_op("rotr8",   2'b10, 32'h1234_5678, 5'd8,  3, 32'h7812_3456);
        run_op("shamt0",  2'b00, 32'hDEAD_BEEF, 5'd0,  1, 32'hDEAD_BEEF);

        // start held high during SHIFT with different inputs must be ignored
        start   = 1'b1;
        op      = 2'b00;
        operand = 32'h0000_0005;
        shamt   = 5'd16;
        @(negedge clk);
        op      = 2'b01;
        operand = 32'h0000_0009;
        shamt   = 5'd1;
        ndone   = 0;
        done_at = 0;
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                done_at = i;
            end
        end
        start = 1'b0;
        chk("ign_result", result, 32'h0005_0000);
        for (int i = 6; i <= 10; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("ign_ndone",  32'(ndone), 32'd1);
        chk("ign_doneat", 32'(done_at), 32'd5);
        chk("ign_hold",   result, 32'h0005_0000);

        // back-to-back: second request accepted in the first one's done cycle
        issue(2'b00, 32'h0000_0003, 5'd2);
        wait_done(20, lat, bcnt);
        chk("b2b1_latency", 32'(lat), 32'd2);
        chk("b2b1_result",  result, 32'h0000_000C);
        issue(2'b01, 32'h0000_00F0, 5'd4);
        chk("b2b_gap_done", 32'(done), 32'd0);
        chk("b2b_gap_busy", 32'(busy), 32'd1);
        wait_done(20, lat, bcnt);
        chk("b2b2_latency", 32'(lat), 32'd2);
        chk("b2b2_result",  result, 32'h0000_000F);
        @(negedge clk);

        // reset in the middle of a long shift discards it
        issue(2'b00, 32'h0000_0001, 5'd20);
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        chk("mrst_busy",   32'(busy), 32'd0);
        chk("mrst_done",   32'(done), 32'd0);
        chk("mrst_result", result, 32'h0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("mrst_nodone", 32'(ndone), 32'd0);
        run_op("post_rst", 2'b00, 32'h0000_0001, 5'd1, 2, 32'h0000_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iter_shifter.md
# iter_shifter

Multi-cycle, parametrised shift/rotate unit for the MIPS datapath, the successor to the single-cycle combinational SLL path. It executes logical-left, logical-right, arithmetic-right and rotate-right on a WIDTH-bit operand, moving at most STEP bit positions per clock. A start/busy/done handshake lets the control unit stall while a shift is in flight. It serves both immediate-shamt (SLL/SRL/SRA/ROTR) and register-shamt (SLLV/SRLV/SRAV/ROTRV) forms; the decoder selects the shamt source.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 8
- STEP, 4, maximum bit positions shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH
- SHAMT_W, $clog2(WIDTH), shift-amount width (derived, not overridden)
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  request; sampled only when the unit can accept
- op  in  2  operation: 00 SLL, 01 SRL, 11 SRA, 10 ROTR
- operand  in  WIDTH  value to shift
- shamt  in  SHAMT_W  shift amount; register forms pass the low SHAMT_W bits
- busy  out  1  high while shifting
- done  out  1  one-cycle pulse; result valid
- result  out  WIDTH  shifted value

## Operation
- States:
  - IDLE: busy = 0, done = 0.
  - SHIFT: busy = 1, done = 0.
  - DONE: busy = 0, done = 1.
- Accept: start = 1 while in IDLE or DONE.
  - On the accepting edge, latch op, acc ← operand, rem ← shamt.
  - Next state is DONE if shamt == 0, else SHIFT.
- SHIFT, per edge:
  - k = min(rem, STEP); acc ← op(acc, k); rem ← rem − k.
  - If the new rem is 0, go to DONE; otherwise stay in SHIFT.
- Per-step operations:
  - SLL: zero fill on the right.
  - SRL: zero fill on the left.
  - SRA: fill with acc[WIDTH−1]. Sign is re-read each step, which is equivalent because it never changes.
  - ROTR: bits leaving bit 0 re-enter at bit WIDTH−1.
- DONE: lasts exactly one cycle. Next state is IDLE, or a new accept if start = 1 (back-to-back).
- Ignored start: start asserted in SHIFT has no effect and is not queued.
- result = acc.
  - Valid and stable from the done cycle until the next accepting edge.
  - Intermediate values are visible during SHIFT and are not to be consumed.
- op values are the four listed; every 2-bit encoding is defined, so there is no illegal-op case.
- Inputs other than start are don't-care outside the accepting cycle.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, result = 0, rem = 0.
- Reset mid-SHIFT or mid-DONE:
  - The next edge returns to IDLE with the reset values above.
  - The in-flight operation is discarded and no done is produced.
  - reset wins over a simultaneous start.
- Latency: start accepted at edge E → done high in the cycle after edge E + ceil(shamt/STEP).
  - shamt = 0: done in the cycle immediately after E.
  - Maximum: 1 + ceil((WIDTH−1)/STEP) cycles; 9 for the defaults.
- busy rises in the cycle after E (when shamt ≠ 0) and falls in the same edge that raises done.
- Throughput: back-to-back accept in the DONE cycle means no idle bubble between operations.

## Structure
- Put opcode constants SHOP_SLL, SHOP_SRL, SHOP_SRA, SHOP_ROTR in the shared constants include used by the decoder, alongside the existing funct constants.
- Put state encodings in the same include as SHST_IDLE, SHST_SHIFT, SHST_DONE.
- Sub-module shift_step: purely combinational single step.
  - Inputs: acc, op, k (width $clog2(STEP)+1).
  - Handles k = 0..STEP.
  - iter_shifter instantiates one and holds all state.

## Test plan
Defaults WIDTH = 32, STEP = 4.
- SLL, operand 0x00000001, shamt 3 → busy for 1 cycle; done 2 cycles after start edge; result 0x00000008.
- SRA, 0x80000000, shamt 31 → 8 SHIFT cycles; done on cycle 9; result 0xFFFFFFFF. SRL with the same inputs → 0x00000001.
- ROTR, 0x00000001, shamt 4 → 0x10000000. ROTR 0x12345678, shamt 8 → 0x78123456.
- shamt 0, SLL 0xDEADBEEF → done the next cycle, busy never high, result 0xDEADBEEF. Then start with operand 0x5 held high during SHIFT of a shamt-16 op → only one done, result from the first request.
- Back-to-back: SLL 0x3 shamt 2, second start asserted in its DONE cycle with SRL 0xF0 shamt 4 → done pulses 2 cycles apart; results 0x0000000C then 0x0000000F.
- reset asserted during SHIFT of SLL 0x1 shamt 20 → next edge busy = 0, done = 0, result = 0, no done pulse. A following SLL 0x1 shamt 1 → 0x00000002.
